ex_mem_stage: RTL and testbench

- EX→MEM pipeline stage directly downstream of the ALU.
- Captures ALU result/status plus forwarded control into a 2-entry elastic buffer (valid/ready handshake).
- Resolves beq branches, detects misaligned memory addresses, and accumulates a sticky status word.
- Drives the data-memory stage and the EX forwarding path.

---
 rtl/ex_mem_stage_pkg.sv | 50 +++++
 rtl/ex_mem_skid_buf.sv | 87 ++++++++
 rtl/ex_mem_stage.sv | 141 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline stage.
//   - default datapath widths
//   - ALU op codes and ALU status bit positions
//   - buffer occupancy states
//   - packed pipeline entry held by the elastic buffer
package ex_mem_stage_pkg;

    localparam int EM_DATA_W     = 32;
    localparam int EM_REG_ADDR_W = 5;
    localparam int EM_STATUS_W   = 8;

    // ALU op codes as produced by the ALU control unit
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_BEQ  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_ADDI = 4'd8;

    // ALU status bit positions
    localparam int ST_ZERO     = 7;
    localparam int ST_HI_NZ    = 6;
    localparam int ST_CARRY    = 5;
    localparam int ST_NEG      = 4;
    localparam int ST_MISALIGN = 3;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [EM_DATA_W-1:0]     result;
        logic [EM_DATA_W-1:0]     store_data;
        logic [EM_REG_ADDR_W-1:0] write_reg;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     addr_err;
    } ex_mem_entry_t;

    // Word accesses must have the two low address bits clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic mem_access);
        return mem_access & (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Generic 2-entry valid/ready elastic buffer (head + skid), FIFO order.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 empties the buffer next cycle; same-cycle input dropped
//   in_valid/in_ready     upstream handshake (in_ready depends on state only)
//   in_data[W]            incoming entry
//   out_valid/out_ready   downstream handshake
//   out_data[W]           head entry
module ex_mem_skid_buf
    import ex_mem_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_reg, state_next;
    logic [W-1:0] head_reg, head_next;
    logic [W-1:0] skid_reg, skid_next;
    logic         accept;
    logic         pop;

    // Both handshake outputs come straight from the state register, so
    // there is no combinational path from out_ready to in_ready.
    assign in_ready  = (state_reg != BUF_TWO);
    assign out_valid = (state_reg != BUF_EMPTY);
    assign out_data  = head_reg;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            BUF_EMPTY: begin
                if (accept) begin
                    head_next  = in_data;
                    state_next = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && pop) begin
                    head_next = in_data;
                end else if (accept) begin
                    skid_next  = in_data;
                    state_next = BUF_TWO;
                end else if (pop) begin
                    state_next = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_next  = skid_reg;
                    state_next = BUF_ONE;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
        // A pop in the flush cycle still completes; everything left is discarded.
        if (flush) begin
            state_next = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BUF_EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage.
// Buffers ALU results in a 2-entry elastic buffer, resolves beq branches at
// accept time, suppresses misaligned memory accesses, keeps a sticky OR of
// ALU status flags and exposes the head entry on the EX forwarding path.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                EX handshake
//   alu_* / pc_plus4 / branch_offset / store_data / write_reg / control bits
//   flush, status_clear              pipeline flush, sticky status clear
//   out_valid/out_ready, out_*       MEM stage head entry
//   branch_taken, branch_target      one-cycle redirect pulse and held target
//   fwd_valid, fwd_reg, fwd_data     forwarding from the head entry
//   status_sticky                    OR of accepted statuses
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W     = EM_DATA_W,
    parameter int REG_ADDR_W = EM_REG_ADDR_W,
    parameter int STATUS_W   = EM_STATUS_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [STATUS_W-1:0]   alu_status,
    input  logic [3:0]            alu_control,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic [DATA_W-1:0]     branch_offset,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  is_branch,
    input  logic                  flush,
    input  logic                  status_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_addr_err,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_target,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [STATUS_W-1:0]   status_sticky
);

    localparam int ENTRY_W = $bits(ex_mem_entry_t);

    ex_mem_entry_t       in_entry;
    ex_mem_entry_t       head_entry;
    logic [ENTRY_W-1:0]  head_bits;
    logic                accept;
    logic                addr_err;
    logic                branch_taken_reg, branch_taken_next;
    logic [DATA_W-1:0]   branch_target_reg, branch_target_next;
    logic [STATUS_W-1:0] status_reg, status_next;

    assign accept   = in_valid & in_ready & ~flush;
    assign addr_err = is_misaligned(alu_result[1:0], mem_read | mem_write);

    // A misaligned access is turned into a non-memory op flagged with addr_err.
    always_comb begin
        in_entry            = '0;
        in_entry.result     = alu_result;
        in_entry.store_data = store_data;
        in_entry.write_reg  = write_reg;
        in_entry.reg_write  = reg_write;
        in_entry.mem_read   = mem_read & ~addr_err;
        in_entry.mem_write  = mem_write & ~addr_err;
        in_entry.addr_err   = addr_err;
    end

    ex_mem_skid_buf #(
        .W(ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign head_entry     = ex_mem_entry_t'(head_bits);
    assign out_alu_result = head_entry.result;
    assign out_store_data = head_entry.store_data;
    assign out_write_reg  = head_entry.write_reg;
    assign out_reg_write  = head_entry.reg_write;
    assign out_mem_read   = head_entry.mem_read;
    assign out_mem_write  = head_entry.mem_write;
    assign out_addr_err   = head_entry.addr_err;

    // Loads are not forwardable from here: their value only exists after MEM.
    assign fwd_valid = out_valid & out_reg_write & (out_write_reg != '0) & ~out_mem_read;
    assign fwd_reg   = out_write_reg;
    assign fwd_data  = out_alu_result;

    // Branches resolve when accepted, not when they leave the buffer.
    // The ALU reports beq equality as result == 1.
    always_comb begin
        branch_taken_next  = accept & is_branch & (alu_control == ALU_BEQ)
                           & (alu_result == DATA_W'(1));
        branch_target_next = branch_target_reg;
        if (branch_taken_next) begin
            branch_target_next = pc_plus4 + (branch_offset << 2);
        end
    end

    // Per-bit sticky update: clear wins over the held value, new status always ORs in.
    for (genvar gi = 0; gi < STATUS_W; gi++) begin : g_sticky
        assign status_next[gi] = (status_reg[gi] & ~status_clear) | (accept & alu_status[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken_reg  <= 1'b0;
            branch_target_reg <= '0;
            status_reg        <= '0;
        end else begin
            branch_taken_reg  <= branch_taken_next;
            branch_target_reg <= branch_target_next;
            status_reg        <= status_next;
        end
    end

    assign branch_taken  = branch_taken_reg;
    assign branch_target = branch_target_reg;
    assign status_sticky = status_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;
    logic [3:0]  alu_control;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic        reg_write, mem_read, mem_write, is_branch;
    logic        flush, status_clear;
    logic        out_valid, out_ready;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_write_reg;
    logic        out_reg_write, out_mem_read, out_mem_write, out_addr_err;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [7:0]  status_sticky;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_status     (alu_status),
        .alu_control    (alu_control),
        .pc_plus4       (pc_plus4),
        .branch_offset  (branch_offset),
        .store_data     (store_data),
        .write_reg      (write_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .is_branch      (is_branch),
        .flush          (flush),
        .status_clear   (status_clear),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_write_reg  (out_write_reg),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_addr_err   (out_addr_err),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .fwd_valid      (fwd_valid),
        .fwd_reg        (fwd_reg),
        .fwd_data       (fwd_data),
        .status_sticky  (status_sticky)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic        exp_bt;
    logic [31:0] exp_tgt;
    logic [7:0]  exp_st;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: compare DUT against the model, advance the model, step the clock.
    // Called at the falling edge with inputs already driven.
    task automatic tick();
        exp_t e;
        logic acc, pop;
        #1;
        if (!rst_n) begin
            sb.delete();
            exp_bt  = 1'b0;
            exp_tgt = '0;
            exp_st  = '0;
        end
        check_eq("out_valid", out_valid, sb.size() != 0);
        check_eq("in_ready", in_ready, sb.size() < 2);
        check_eq("branch_taken", branch_taken, exp_bt);
        check_eq("branch_target", branch_target, exp_tgt);
        check_eq("status_sticky", status_sticky, exp_st);
        if (sb.size() != 0) begin
            e = sb[0];
            check_eq("head_result", out_alu_result, e.res);
            check_eq("head_store_data", out_store_data, e.sd);
            check_eq("head_write_reg", out_write_reg, e.wr);
            check_eq("head_reg_write", out_reg_write, e.rw);
            check_eq("head_mem_read", out_mem_read, e.mr);
            check_eq("head_mem_write", out_mem_write, e.mw);
            check_eq("head_addr_err", out_addr_err, e.err);
            check_eq("fwd_valid", fwd_valid, e.rw && (e.wr != 0) && !e.mr);
            check_eq("fwd_reg", fwd_reg, e.wr);
            check_eq("fwd_data", fwd_data, e.res);
        end
        if (rst_n) begin
            acc = in_valid && (sb.size() < 2) && !flush;
            pop = (sb.size() != 0) && out_ready;
            if (pop) begin
                e = sb.pop_front();
                $display("pop    res=%08h wr=%0d rw=%0b mr=%0b mw=%0b err=%0b",
                         e.res, e.wr, e.rw, e.mr, e.mw, e.err);
            end
            if (flush) sb.delete();
            if (acc) begin
                e.res = alu_result;
                e.sd  = store_data;
                e.wr  = write_reg;
                e.rw  = reg_write;
                e.err = (mem_read || mem_write) && (alu_result[1:0] != 2'b00);
                e.mr  = mem_read && !e.err;
                e.mw  = mem_write && !e.err;
                sb.push_back(e);
                $display("accept res=%08h wr=%0d st=%02h ctl=%0d br=%0b",
                         alu_result, write_reg, alu_status, alu_control, is_branch);
            end
            exp_bt = acc && is_branch && (alu_control == 4'd4) && (alu_result == 32'd1);
            if (exp_bt) exp_tgt = pc_plus4 + {branch_offset[29:0], 2'b00};
            if (acc) exp_st = (status_clear ? 8'h00 : exp_st) | alu_status;
            else if (status_clear) exp_st = 8'h00;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] res, input logic [4:0] wr, input logic rw,
                         input logic mr, input logic mw, input logic [7:0] st);
        in_valid      = 1'b1;
        alu_result    = res;
        store_data    = res ^ 32'hA5A5_0000;
        write_reg     = wr;
        reg_write     = rw;
        mem_read      = mr;
        mem_write     = mw;
        alu_status    = st;
        alu_control   = 4'd2;
        is_branch     = 1'b0;
        pc_plus4      = 32'h0000_0040;
        branch_offset = 32'h0000_0003;
    endtask

    task automatic drive_beq(input logic [31:0] res);
        drive(res, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        alu_control   = 4'd4;
        is_branch     = 1'b1;
        pc_plus4      = 32'h0000_0100;
        branch_offset = 32'hFFFF_FFFE;
    endtask

    // Hold the driven entry until the model says it was taken, bounded.
    task automatic wait_accept();
        logic acc;
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            acc = in_valid && (sb.size() < 2) && !flush;
            tick();
            if (acc) done = 1'b1;
        end
        if (!done) check_eq("accept_timeout", 1'b0, 1'b1);
        in_valid     = 1'b0;
        status_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; alu_result = 0; alu_status = 0; alu_control = 0;
        pc_plus4 = 0; branch_offset = 0; store_data = 0; write_reg = 0;
        reg_write = 0; mem_read = 0; mem_write = 0; is_branch = 0;
        flush = 0; status_clear = 0; out_ready = 1'b1;
        exp_bt = 0; exp_tgt = 0; exp_st = 0;

        // Reset state
        tick();
        check_eq("rst_out_result", out_alu_result, 32'h0);
        check_eq("rst_addr_err", out_addr_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Simple add result, forwarded next cycle
        drive(32'h0000_0010, 5'd8, 1'b1, 1'b0, 1'b0, 8'h00);
        wait_accept();
        check_eq("add_fwd_valid", fwd_valid, 1'b1);
        check_eq("add_fwd_reg", fwd_reg, 5'd8);
        check_eq("add_result", out_alu_result, 32'h10);
        idle(2);

        // Back-to-back with backpressure: two fit, the third waits
        out_ready = 1'b0;
        drive(32'h0000_0100, 5'd1, 1'b1, 1'b0, 1'b0, 8'h00); wait_accept();
        drive(32'h0000_0200, 5'd2, 1'b1, 1'b0, 1'b0, 8'h00); wait_accept();
        drive(32'h0000_0300, 5'd3, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        check_eq("full_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        wait_accept();
        idle(4);

        // beq taken, then not taken
        drive_beq(32'd1);
        wait_accept();
        check_eq("beq_pulse", branch_taken, 1'b1);
        check_eq("beq_target", branch_target, 32'h0000_00F8);
        idle(1);
        check_eq("beq_pulse_end", branch_taken, 1'b0);
        drive_beq(32'd0);
        wait_accept();
        check_eq("beq_not_taken", branch_taken, 1'b0);
        check_eq("beq_target_hold", branch_target, 32'h0000_00F8);
        idle(2);

        // Misaligned store, aligned load
        drive(32'h0000_1002, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
        wait_accept();
        check_eq("sw_mis_mem_write", out_mem_write, 1'b0);
        check_eq("sw_mis_addr_err", out_addr_err, 1'b1);
        drive(32'h0000_1000, 5'd9, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_accept();
        check_eq("lw_mem_read", out_mem_read, 1'b1);
        check_eq("lw_fwd_valid", fwd_valid, 1'b0);
        idle(2);

        // Flush in TWO with a taken-branch input
        out_ready = 1'b0;
        drive(32'h0000_0400, 5'd4, 1'b1, 1'b0, 1'b0, 8'h00); wait_accept();
        drive(32'h0000_0500, 5'd5, 1'b1, 1'b0, 1'b0, 8'h00); wait_accept();
        drive_beq(32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush2_out_valid", out_valid, 1'b0);
        check_eq("flush2_in_ready", in_ready, 1'b1);
        check_eq("flush2_branch", branch_taken, 1'b0);
        out_ready = 1'b1;

        // Flush in ONE: the acceptable branch input must be dropped
        drive(32'h0000_0600, 5'd6, 1'b1, 1'b0, 1'b0, 8'h00); wait_accept();
        drive_beq(32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush1_out_valid", out_valid, 1'b0);
        check_eq("flush1_branch", branch_taken, 1'b0);
        idle(1);

        // Sticky status
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        drive(32'h0000_0700, 5'd7, 1'b1, 1'b0, 1'b0, 8'h80); wait_accept();
        drive(32'h0000_0704, 5'd7, 1'b1, 1'b0, 1'b0, 8'h10); wait_accept();
        check_eq("sticky_or", status_sticky, 8'h90);
        drive(32'h0000_0708, 5'd7, 1'b1, 1'b0, 1'b0, 8'h40);
        status_clear = 1'b1;
        wait_accept();
        check_eq("sticky_clear_acc", status_sticky, 8'h40);
        idle(2);

        // Reset mid-operation discards held entries
        out_ready = 1'b0;
        drive(32'h0000_0800, 5'd10, 1'b1, 1'b0, 1'b0, 8'h01); wait_accept();
        drive(32'h0000_0804, 5'd11, 1'b1, 1'b0, 1'b0, 8'h02); wait_accept();
        rst_n = 1'b0;
        tick();
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_sticky", status_sticky, 8'h00);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
